// File: rtl/square_synth.sv
// N-channel square-wave synthesiser: phase accumulators, duty/octave tone, decay envelope, sigma-delta PWM.
// Latency: one cycle from phase/volume state to mix, one more cycle from mix to pwm_out.
// Backpressure: none; all inputs are sampled every cycle and the outputs stream continuously.
module square_synth #(
    parameter int NCH   = 2,
    parameter int INC_W = 8,
    parameter int PHA_W = 16,
    parameter int OCT_W = 2,
    parameter int VOL_W = 6,
    localparam int MIX_W = VOL_W + $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   env_tick,
    input  logic [NCH*INC_W-1:0]   note_inc,
    input  logic [NCH*OCT_W-1:0]   octave,
    input  logic [NCH*2-1:0]       duty,
    input  logic [NCH*2-1:0]       decay,
    input  logic [NCH-1:0]         trigger,
    output logic [MIX_W-1:0]       mix,
    output logic                   pwm_out
);

    localparam logic [VOL_W-1:0] VOL_MAX = '1;

    logic [NCH-1:0][PHA_W-1:0] pha;
    logic [NCH-1:0][VOL_W-1:0] vol;
    logic [NCH-1:0][2:0]       tone_bits;
    logic [NCH-1:0]            tone_on;
    logic [MIX_W-1:0]          sum_next;
    logic [MIX_W-1:0]          acc;
    logic [MIX_W:0]            acc_next;

    // Pick the three phase bits at and below the octave-selected tap, then apply the duty pattern.
    always_comb begin
        tone_bits = '0;
        tone_on   = '0;
        for (int c = 0; c < NCH; c++) begin
            tone_bits[c] = 3'(pha[c] >> (PHA_W - 3 - int'(octave[c*OCT_W +: OCT_W])));
            case (duty[c*2 +: 2])
                2'd0:    tone_on[c] = tone_bits[c][2];
                2'd1:    tone_on[c] = tone_bits[c][2] & tone_bits[c][1];
                2'd2:    tone_on[c] = &tone_bits[c];
                default: tone_on[c] = tone_bits[c][2] | tone_bits[c][1];
            endcase
        end
    end

    // Channel sum from the current (pre-update) registered tone and volume.
    always_comb begin
        sum_next = '0;
        for (int c = 0; c < NCH; c++) begin
            if (tone_on[c]) begin
                sum_next = sum_next + MIX_W'(vol[c]);
            end
        end
    end

    // First-order sigma-delta: the carry out of the accumulator is the PWM bit.
    always_comb begin
        acc_next = {1'b0, acc} + {1'b0, mix};
    end

    // Phase accumulators advance on sample_tick and wrap freely; control changes never touch phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pha <= '0;
        end else if (sample_tick) begin
            for (int c = 0; c < NCH; c++) begin
                pha[c] <= pha[c] + PHA_W'(note_inc[c*INC_W +: INC_W]);
            end
        end
    end

    // Envelope: trigger reloads full volume and beats a same-cycle decay step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vol <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (trigger[c]) begin
                    vol[c] <= VOL_MAX;
                end else if (env_tick) begin
                    // Shift of 1..4; the step reaches zero at a sustain floor rather than silence.
                    vol[c] <= vol[c] - (vol[c] >> (3'(decay[c*2 +: 2]) + 3'd1));
                end
            end
        end
    end

    // Registered mix and PWM stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix     <= '0;
            acc     <= '0;
            pwm_out <= 1'b0;
        end else begin
            mix     <= sum_next;
            acc     <= acc_next[MIX_W-1:0];
            pwm_out <= acc_next[MIX_W];
        end
    end

endmodule

// File: doc/square_synth.md
Name: square_synth

Overview:
- Parametrised N-channel square-wave synthesiser with per-channel phase accumulator, octave select, duty select and exponential-decay volume envelope.
- Channels are summed and converted to a 1-bit first-order sigma-delta PWM stream for the audio pin.
- Sequencing stays outside this block. An external song sequencer drives note increments, octaves, duties, decay rates and triggers.
- It is clocked by the pixel clock. sample_tick is typically one pulse per scanline; env_tick is one pulse per frame.

Parameters:
- NCH, 2, number of channels (1..8)
- INC_W, 8, phase increment width per channel
- PHA_W, 16, phase accumulator width (must satisfy PHA_W >= 2^OCT_W + 2)
- OCT_W, 2, octave select width
- VOL_W, 6, envelope volume width
- MIX_W, VOL_W + clog2(NCH), mixer and PWM accumulator width (derived, not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle pulse: advance all phase accumulators
- env_tick  in  1  one-cycle pulse: apply one envelope decay step to all channels
- note_inc  in  NCH*INC_W  packed per-channel phase increment; channel c occupies [c*INC_W +: INC_W]
- octave  in  NCH*OCT_W  packed per-channel octave; higher value gives higher pitch
- duty  in  NCH*2  packed per-channel duty code
- decay  in  NCH*2  packed per-channel decay code
- trigger  in  NCH  per-channel note-on, level-sampled every cycle
- mix  out  MIX_W  registered channel sum (debug and DAC use)
- pwm_out  out  1  registered sigma-delta PWM bit

Behaviour:
- Reset (asynchronous, active-high):
  - all phase accumulators, volumes, the mix register, the PWM accumulator and pwm_out clear to 0.
  - Reset asserted mid-note silences the block immediately.
  - After release, nothing sounds until the next trigger.
- Phase accumulator, per channel c:
  - on sample_tick, pha[c] <= pha[c] + zero-extended note_inc[c].
  - Wraps modulo 2^PHA_W with no saturation.
  - Without sample_tick, pha holds.
- Tone bit: k = PHA_W-1-octave[c].
  - duty 0: 50%, on = pha[k]
  - duty 1: 25%, on = pha[k] & pha[k-1]
  - duty 2: 12.5%, on = pha[k] & pha[k-1] & pha[k-2]
  - duty 3: 75%, on = pha[k] | pha[k-1]
- Envelope, per channel, evaluated every cycle in priority order:
  - trigger[c]=1: vol <= 2^VOL_W-1, regardless of env_tick in the same cycle (trigger wins).
  - else if env_tick: vol <= vol - (vol >> (decay[c]+1)), giving shift 1..4.
  - else vol holds.
  - Decay floor: vol stops at 2^(decay+1)-1 because the shift term reaches 0. This is intended as a sustain floor; the block does not force vol to zero.
- Sample: s[c] = on ? vol[c] : 0. Both on and vol come from registered state, using pre-update values.
- Mix:
  - mix <= sum of s[c], updated every cycle.
  - One-cycle latency from a pha/vol change to mix.
  - Width MIX_W guarantees no overflow.
- PWM:
  - acc_next = acc + mix, computed at MIX_W+1 bits.
  - acc <= acc_next[MIX_W-1:0]; pwm_out <= acc_next[MIX_W].
  - Density of pwm_out is mix/2^MIX_W. Any 2^MIX_W consecutive cycles with constant mix contain exactly mix ones.
- sample_tick and env_tick in the same cycle: both take effect independently.
- All control inputs are sampled synchronously. Changing note_inc, octave, duty or decay never resets phase (glitch-free pitch change).

Test Plan:
1. Hold reset 10 cycles, then release with all inputs 0 for 300 cycles -> mix=0 and pwm_out=0 throughout; assert reset asynchronously mid-cycle -> all outputs 0 before the next edge.
2. ch0: inc=0x80, oct=0, duty=0; one-cycle trigger; sample_tick every cycle; no env_tick -> vol=63; pha[15] toggles every 256 ticks; mix alternates 0/63 in 256-cycle runs; during a 63 run, any 128-cycle window has exactly 63 pwm_out ones.
3. ch0: decay=2 (shift 3), trigger then 6 env_ticks -> vol sequence 63,56,49,43,38,34,30; continued ticks settle at floor 7 and never go lower.
4. ch1: oct=3, duty=1, inc=0x01, sample_tick every cycle -> tone bit k=12; on-time is 2048 of every 8192 ticks (25%); with duty=3 -> 6144 of 8192.
5. trigger and env_tick in the same cycle with vol=20 -> vol=63 next cycle, not decayed; both channels triggered at 63 with both on -> mix=126.
6. Change note_inc 0x80->0x40 at pha=0x1234 -> pha continues 0x1234+0x40 on the next tick, with no reset of pha and no spurious tone-bit edge.
